// File: rtl/jk_excite_seq_if.sv
// Target-word handshake between an upstream producer and jk_excite_seq.
interface jk_excite_seq_if #(
  parameter int unsigned WIDTH = 4
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;

  modport master (output tgt_valid, output tgt_data, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/jk_excite_seq.sv
// Drives J/K excitation into a master-slave JK bank for one capture edge, then
// reads the bank back after a settle delay and flags any mismatch.
module jk_excite_seq #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned USE_TOGGLE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  jk_excite_seq_if.slave    tgt,
  output logic [WIDTH-1:0]  j_o,
  output logic [WIDTH-1:0]  k_o,
  input  logic [WIDTH-1:0]  q_fb_i,
  output logic [WIDTH-1:0]  cur_q_o,
  output logic              done_o,
  output logic              err_o,
  output logic [7:0]        err_cnt_o
);

  localparam int unsigned CntW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDrive  = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;
  localparam logic [1:0] StCheck  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic [WIDTH-1:0] cur_q_q, cur_q_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             mismatch;

  assign mismatch      = (q_fb_i != tgt_q);
  assign tgt.tgt_ready = (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    j_d       = '0;
    k_d       = '0;
    cur_q_d   = cur_q_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    case (state_q)
      StIdle: begin
        if (tgt.tgt_valid) begin
          tgt_d = tgt.tgt_data;
          // Toggle coding flips only the bits that differ from the shadow copy.
          if (USE_TOGGLE != 0) begin
            j_d = tgt.tgt_data ^ cur_q_q;
            k_d = tgt.tgt_data ^ cur_q_q;
          end else begin
            j_d = tgt.tgt_data;
            k_d = ~tgt.tgt_data;
          end
          state_d = StDrive;
        end
      end
      StDrive: begin
        cnt_d   = CntW'(SETTLE_CYC - 1);
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StCheck: begin
        done_d  = 1'b1;
        err_d   = mismatch;
        // Resync to what the bank really holds, even on error.
        cur_q_d = q_fb_i;
        if (mismatch && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tgt_q     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      cur_q_q   <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      cur_q_q   <= cur_q_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign j_o       = j_q;
  assign k_o       = k_q;
  assign cur_q_o   = cur_q_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_jk_excite_seq.sv
// Scoreboard bench: DUT 0 uses set/reset coding with SETTLE_CYC=1, DUT 1 uses
// toggle coding with SETTLE_CYC=3; each drives its own behavioural JK bank.
module tb_jk_excite_seq;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  jk_excite_seq_if #(.WIDTH(4)) if_a ();
  jk_excite_seq_if #(.WIDTH(4)) if_b ();

  logic [3:0] j [2];
  logic [3:0] k [2];
  logic [3:0] cur_q [2];
  logic [3:0] q_fb [2];
  logic       done [2];
  logic       err [2];
  logic [7:0] err_cnt [2];
  logic       rdy [2];
  logic       vld [2];
  logic       stuck [2];
  logic [3:0] bm [2] = '{4'h0, 4'h0};
  logic [3:0] bs [2] = '{4'h0, 4'h0};

  jk_excite_seq #(.WIDTH(4), .SETTLE_CYC(1), .USE_TOGGLE(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tgt(if_a.slave),
    .j_o(j[0]), .k_o(k[0]), .q_fb_i(q_fb[0]), .cur_q_o(cur_q[0]),
    .done_o(done[0]), .err_o(err[0]), .err_cnt_o(err_cnt[0])
  );

  jk_excite_seq #(.WIDTH(4), .SETTLE_CYC(3), .USE_TOGGLE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tgt(if_b.slave),
    .j_o(j[1]), .k_o(k[1]), .q_fb_i(q_fb[1]), .cur_q_o(cur_q[1]),
    .done_o(done[1]), .err_o(err[1]), .err_cnt_o(err_cnt[1])
  );

  assign rdy[0]  = if_a.tgt_ready;
  assign rdy[1]  = if_b.tgt_ready;
  assign vld[0]  = if_a.tgt_valid;
  assign vld[1]  = if_b.tgt_valid;
  assign q_fb[0] = stuck[0] ? 4'h0 : bs[0];
  assign q_fb[1] = stuck[1] ? 4'h0 : bs[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural master-slave JK bank (no reset).
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) bm[d] <= (j[d] & ~bm[d]) | (~k[d] & bm[d]);
  end
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) bs[d] <= bm[d];
  end

  // Expectation FIFOs: J/K popped at accept, result popped at done.
  logic [3:0] e_j [2][16];
  logic [3:0] e_k [2][16];
  logic       e_err [2][16];
  logic [3:0] e_cur [2][16];
  logic [7:0] e_cnt [2][16];
  int         jk_wr [2] = '{0, 0};
  int         jk_rd [2] = '{0, 0};
  int         sb_wr [2] = '{0, 0};
  int         sb_rd [2] = '{0, 0};
  logic       acc_q [2] = '{1'b0, 1'b0};
  logic       jk_chk [2] = '{1'b0, 1'b0};
  logic       busy [2] = '{1'b0, 1'b0};
  int         acc_cyc [2] = '{0, 0};

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at cycle %0d", name, d, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) acc_q[d] <= rst_n & vld[d] & rdy[d];
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (acc_q[d]) begin
          if (jk_rd[d] == jk_wr[d]) begin
            chk("unexpected_accept", d, 32'd1, 32'd0);
          end else begin
            chk("j_drive", d, 32'(j[d]), 32'(e_j[d][jk_rd[d] % 16]));
            chk("k_drive", d, 32'(k[d]), 32'(e_k[d][jk_rd[d] % 16]));
            jk_rd[d]++;
          end
          jk_chk[d]  = 1'b1;
          acc_cyc[d] = cyc;
          busy[d]    = 1'b1;
        end else if (jk_chk[d]) begin
          chk("jk_clear", d, 32'({j[d], k[d]}), 32'd0);
          jk_chk[d] = 1'b0;
        end
        if (done[d]) begin
          if (sb_rd[d] == sb_wr[d]) begin
            chk("unexpected_done", d, 32'd1, 32'd0);
          end else begin
            chk("err", d, 32'(err[d]), 32'(e_err[d][sb_rd[d] % 16]));
            chk("cur_q", d, 32'(cur_q[d]), 32'(e_cur[d][sb_rd[d] % 16]));
            chk("err_cnt", d, 32'(err_cnt[d]), 32'(e_cnt[d][sb_rd[d] % 16]));
            chk("latency", d, 32'(cyc - acc_cyc[d]), 32'(settle_of(d) + 2));
            chk("ready_at_done", d, 32'(rdy[d]), 32'd1);
            sb_rd[d]++;
          end
          busy[d] = 1'b0;
        end else begin
          if (err[d]) chk("err_without_done", d, 32'd1, 32'd0);
          if (busy[d]) chk("ready_low_busy", d, 32'(rdy[d]), 32'd0);
        end
      end
    end
  end

  task automatic set_in(input int d, input logic v, input logic [3:0] data);
    if (d == 0) begin
      if_a.tgt_valid = v;
      if_a.tgt_data  = data;
    end else begin
      if_b.tgt_valid = v;
      if_b.tgt_data  = data;
    end
  endtask

  task automatic send(input int d, input logic [3:0] data, input logic [3:0] ej,
                      input logic [3:0] ek, input logic eerr, input logic [3:0] ecur,
                      input logic [7:0] ecnt, input bit hold, output int acc_at);
    e_j[d][jk_wr[d] % 16]   = ej;
    e_k[d][jk_wr[d] % 16]   = ek;
    jk_wr[d]++;
    e_err[d][sb_wr[d] % 16] = eerr;
    e_cur[d][sb_wr[d] % 16] = ecur;
    e_cnt[d][sb_wr[d] % 16] = ecnt;
    sb_wr[d]++;
    acc_at = -1;
    @(negedge clk);
    set_in(d, 1'b1, data);
    for (int n = 0; n < 50; n++) begin
      if (rdy[d]) begin
        @(posedge clk);
        #1;
        acc_at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc_at < 0) chk("accept_timeout", d, 32'd0, 32'd1);
    if (!hold) set_in(d, 1'b0, data);
  endtask

  task automatic drain(input int d);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (sb_rd[d] == sb_wr[d] && !busy[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", d, 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk("rst_jk", d, 32'({j[d], k[d]}), 32'd0);
      chk("rst_cur_q", d, 32'(cur_q[d]), 32'd0);
      chk("rst_done_err", d, 32'({done[d], err[d]}), 32'd0);
      chk("rst_err_cnt", d, 32'(err_cnt[d]), 32'd0);
      chk("rst_ready", d, 32'(rdy[d]), 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int a1;
    rst_n    = 1'b0;
    stuck[0] = 1'b0;
    stuck[1] = 1'b0;
    set_in(0, 1'b0, 4'h0);
    set_in(1, 1'b0, 4'h0);
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // Basic set/reset accept.
    send(0, 4'b1010, 4'b1010, 4'b0101, 1'b0, 4'b1010, 8'd0, 1'b0, a0);
    drain(0);

    // Toggle coding: 0000->1010, then 1010->0110 drives j=k=1100.
    send(1, 4'b1010, 4'b1010, 4'b1010, 1'b0, 4'b1010, 8'd0, 1'b0, a0);
    drain(1);
    send(1, 4'b0110, 4'b1100, 4'b1100, 1'b0, 4'b0110, 8'd0, 1'b0, a0);
    drain(1);

    // Back-to-back with valid held high.
    send(0, 4'b0001, 4'b0001, 4'b1110, 1'b0, 4'b0001, 8'd0, 1'b1, a0);
    send(0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b1111, 8'd0, 1'b0, a1);
    chk("b2b_spacing", 0, 32'(a1 - a0), 32'd4);
    drain(0);

    // Error path with readback stuck at zero.
    stuck[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(0, 4'b0011, 4'b0011, 4'b1100, 1'b1, 4'b0000, 8'(i + 1), 1'b0, a0);
      drain(0);
    end

    // Push err_cnt to 255, then one more error must saturate.
    for (int i = 0; i < 252; i++) begin
      send(0, 4'b0101, 4'b0101, 4'b1010, 1'b1, 4'b0000, 8'(i + 4), 1'b0, a0);
      drain(0);
    end
    send(0, 4'b0101, 4'b0101, 4'b1010, 1'b1, 4'b0000, 8'd255, 1'b0, a0);
    drain(0);
    stuck[0] = 1'b0;
    send(0, 4'b0101, 4'b0101, 4'b1010, 1'b0, 4'b0101, 8'd255, 1'b0, a0);
    drain(0);

    // Toggle DUT: bring bank to 1111, then re-target 1111 (j=k=0) and abort in SETTLE.
    send(1, 4'b1111, 4'b1001, 4'b1001, 1'b0, 4'b1111, 8'd0, 1'b0, a0);
    drain(1);
    send(1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b1111, 8'd0, 1'b0, a0);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb_rd[1]  = sb_wr[1];
    busy[1]   = 1'b0;
    jk_chk[1] = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("bank_held", 1, 32'(q_fb[1]), 32'hF);

    // Stale shadow: first 0000 lands wrong and resyncs, second lands correctly.
    send(1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b1111, 8'd1, 1'b0, a0);
    drain(1);
    send(1, 4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0000, 8'd1, 1'b0, a0);
    drain(1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
